uart_tx_port: RTL

- Memory-mapped serial output stage directly downstream of the RISC CPU core's external bus (addr, data, wr).
- Snoops CPU store cycles to a single I/O address and pushes each byte into a small FIFO.
- Drains the FIFO as 8N1 asynchronous serial frames on txd, so programs in ROM can print results without stalling the core.

---
 rtl/uart_tx_port_if.sv | 12 +
 rtl/uart_tx_port.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port_if.sv
// CPU store-bus bundle seen by the serial output port: address, data and write strobe.
// No latency of its own: plain wires with no registers.
// No backpressure: the CPU never stalls, and the port only samples these signals.
// Ports (modports): master = CPU side (drives addr/data/wr), slave = port side (samples them).
interface uart_tx_port_if;
  logic [12:0] addr;
  logic [7:0]  data;
  logic        wr;

  modport master (output addr, output data, output wr);
  modport slave  (input addr, input data, input wr);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped serial output stage: snoops CPU stores to IO_ADDR and sends each byte as an 8N1 frame on txd.
// Latency: from the clk edge that samples wr rising, txd falls two edges later; frames repeat every 10*CLKS_PER_BIT+1 cycles.
// No backpressure to the CPU: when the FIFO is full, the byte is dropped and the sticky overflow flag is set.
// Ports: clk, reset (async, active-high), bus (uart_tx_port_if.slave: addr/data/wr),
//        txd (serial out, idle high), busy, fifo_full, overflow (status, registered).
// Build option: UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit (8E1).
module uart_tx_port #(
  parameter logic [12:0] IO_ADDR      = 13'h1FFF,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_AW      = 2
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_port_if.slave bus,
  output logic          txd,
  output logic          busy,
  output logic          fifo_full,
  output logic          overflow
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic                wr_q;
  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wptr_q, rptr_q;
  logic [FIFO_AW:0]    count_q;
  logic                fifo_empty, push_req, pop, push_ok, baud_last;

  assign fifo_empty = (count_q == '0);
  // The edge detect gives exactly one push per wr pulse, however long the CPU holds wr.
  assign push_req   = bus.wr && !wr_q && (bus.addr == IO_ADDR);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A full FIFO can still take a byte when its head leaves in the same cycle.
  assign push_ok    = push_req && ((count_q != CNT_FULL) || pop);
  assign baud_last  = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      fifo_full <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_q <= bus.wr;
      if (push_ok) begin
        mem[wptr_q] <= bus.data;
        wptr_q      <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
      busy      <= (state_q != S_IDLE) || !fifo_empty;
      fifo_full <= (count_q == CNT_FULL);
    end
  end

  // txd is registered from the current state, which adds one cycle to every bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd      <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          shift_d  = mem[rptr_q];
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem[rptr_q];
`endif
          baud_d   = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        txd_d = parity_q;
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        txd_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
